// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: op encodings, FSM states and counter width shared by the md sequencer
package muldiv_sequencer_pkg;
  localparam int CNT_W = 4;
  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/muldiv_arith.sv
// muldiv_arith: combinational HI/LO result for one mult/div command
module muldiv_arith
  import muldiv_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] cur_hi,
  input  logic [31:0] cur_lo,
  output logic [31:0] pending_hi,
  output logic [31:0] pending_lo
);
  logic        sgn;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, q, r;
  logic [63:0] sprod, uprod;
  // Signed divide runs on magnitudes; sign fix-up also yields 0x80000000/-1 = 0x80000000 rem 0
  always_comb begin
    sprod = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    uprod = {32'b0, rs_val} * {32'b0, rt_val};
    sgn = op == MD_DIV;
    a_mag = sgn & rs_val[31] ? -rs_val : rs_val;
    b_mag = sgn & rt_val[31] ? -rt_val : rt_val;
    b_safe = b_mag == 32'd0 ? 32'd1 : b_mag;
    uq = a_mag / b_safe;
    ur = a_mag % b_safe;
    q = sgn & (rs_val[31] ^ rt_val[31]) ? -uq : uq;
    r = sgn & rs_val[31] ? -ur : ur;
    {pending_hi, pending_lo} = op == MD_MULT  ? sprod :
                               op == MD_MULTU ? uprod :
                               (op == MD_DIV || op == MD_DIVU) && rt_val != 32'd0 ? {r, q} :
                               {cur_hi, cur_lo};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO sequencer with cancel and decode stall
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  input  logic        d_md_use,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo, arith_hi, arith_lo;
  logic             is_md, is_mul;
  muldiv_arith u_arith (
    .op(op), .rs_val(rs_val), .rt_val(rt_val), .cur_hi(hi), .cur_lo(lo),
    .pending_hi(arith_hi), .pending_lo(arith_lo)
  );
  // Command decode and the decode-stage stall
  always_comb begin
    is_mul = op == MD_MULT || op == MD_MULTU;
    is_md = is_mul || op == MD_DIV || op == MD_DIVU;
    stall = d_md_use & (busy | (start & is_md));
  end
  // FSM, latency counter and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (state == IDLE) begin
      if (start && !cancel && is_md) begin
        pend_hi <= arith_hi;
        pend_lo <= arith_lo;
        cnt <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        state <= BUSY;
        busy <= 1'b1;
      end else if (start && !cancel && op == MD_MTHI) begin
        hi <= rs_val;
      end else if (start && !cancel && op == MD_MTLO) begin
        lo <= rs_val;
      end
    end else if (cancel || cnt == CNT_W'(1)) begin
      hi <= cancel ? hi : pend_hi;
      lo <= cancel ? lo : pend_lo;
      cnt <= '0;
      state <= IDLE;
      busy <= 1'b0;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of latency, results, cancel, stall and async reset
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
  logic        clk = 0, reset = 0, start = 0, cancel = 0, d_md_use = 0;
  logic [3:0]  op = MD_NOP;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic        busy, stall;
  logic [31:0] hi, lo;
  int checks = 0, errors = 0;

  muldiv_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .d_md_use(d_md_use), .busy(busy), .hi(hi), .lo(lo), .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start && busy) begin
      errors++;
      $display("FAIL protocol: start=%0b while busy=%0b (want no start while busy)", start, busy);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1; op = o; rs_val = a; rt_val = b;
    step(1);
    start = 0; op = MD_NOP;
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input logic [31:0] eh,
                        input logic [31:0] el);
    int n;
    issue(o, a, b);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step(1);
    end
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s busy cycles: got %0d want %0d", name, n, exp_n);
    end
    checks++;
    if (hi !== eh || lo !== el) begin
      errors++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, eh, el);
    end
  endtask

  task automatic test_reset;
    reset = 1;
    #2;
    reset = 0;
    step(1);
    checks++;
    if (busy !== 0 || hi !== 0 || lo !== 0 || stall !== 0) begin
      errors++;
      $display("FAIL reset: got busy=%b hi=%h lo=%h stall=%b want 0/0/0/0", busy, hi, lo, stall);
    end
  endtask

  task automatic test_mult;
    run_op("mult", MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", MD_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
  endtask

  task automatic test_div;
    run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu", MD_DIVU, 32'd100, 32'd7, 10, 32'd2, 32'd14);
    run_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000);
  endtask

  task automatic test_move;
    int seen;
    seen = 0;
    issue(MD_MTHI, 32'h1234, 32'd0);
    seen |= busy;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h80000000) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h want hi=00001234 lo=80000000", hi, lo);
    end
    issue(MD_MTLO, 32'h5678, 32'd0);
    seen |= busy;
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || seen !== 0) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h busy_seen=%0d want 00001234/00005678/0", hi, lo, seen);
    end
    cancel = 1;
    issue(MD_MTHI, 32'hDEAD, 32'd0);
    cancel = 0;
    checks++;
    if (hi !== 32'h1234) begin
      errors++;
      $display("FAIL idle_cancel: got hi=%h want 00001234", hi);
    end
  endtask

  task automatic test_cancel;
    issue(MD_MULT, 32'd10, 32'd10);
    step(2);
    cancel = 1;
    step(1);
    cancel = 0;
    checks++;
    if (busy !== 0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      errors++;
      $display("FAIL cancel_mid: got busy=%b hi=%h lo=%h want 0/00001234/00005678", busy, hi, lo);
    end
    issue(MD_MULT, 32'd10, 32'd10);
    step(4);
    checks++;
    if (busy !== 1) begin
      errors++;
      $display("FAIL cancel_last_busy: got busy=%b want 1", busy);
    end
    cancel = 1;
    step(1);
    cancel = 0;
    checks++;
    if (busy !== 0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      errors++;
      $display("FAIL cancel_last: got busy=%b hi=%h lo=%h want 0/00001234/00005678", busy, hi, lo);
    end
  endtask

  task automatic test_stall;
    int bad;
    bad = 0;
    d_md_use = 1;
    op = MD_NOP;
    #1;
    checks++;
    if (stall !== 0) begin
      errors++;
      $display("FAIL stall_idle: got %b want 0", stall);
    end
    start = 1; op = MD_MULT; rs_val = 32'd6; rt_val = 32'd7;
    #1;
    checks++;
    if (stall !== 1) begin
      errors++;
      $display("FAIL stall_start: got %b want 1", stall);
    end
    step(1);
    start = 0; op = MD_NOP;
    for (int i = 0; i < 5; i++) begin
      if (stall !== 1) bad++;
      step(1);
    end
    checks++;
    if (bad !== 0 || stall !== 0 || busy !== 0 || lo !== 32'd42) begin
      errors++;
      $display("FAIL stall_window: got bad=%0d stall=%b busy=%b lo=%h want 0/0/0/0000002a", bad, stall, busy, lo);
    end
    d_md_use = 0;
    run_op("back_to_back", MD_MULTU, 32'd3, 32'd5, 5, 32'd0, 32'd15);
  endtask

  task automatic test_async_reset;
    issue(MD_DIV, 32'd9, 32'd2);
    step(3);
    #2;
    reset = 1;
    #1;
    checks++;
    if (busy !== 0 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    reset = 0;
    step(12);
    checks++;
    if (busy !== 0 || hi !== 0 || lo !== 0) begin
      errors++;
      $display("FAIL after_reset: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_cancel();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
